// File: rtl/insn_fetch_unit.sv
// Instruction fetch/assembly stage: reads one program word per cycle and packs each
// opcode with its trailing immediate words into a bundle delivered over valid/ready.
module insn_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter logic [6:0]  DUAL_DST_OP0 = 7'd18,
    parameter logic [6:0]  DUAL_DST_OP1 = 7'd34
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_word,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_imm1,
    output logic [31:0] out_imm2,
    output logic [31:0] out_pc,
    output logic [1:0]  out_len
);

    typedef enum logic [1:0] {FETCH, IMM1, IMM2, VALID} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic [31:0] bpc;
    logic [1:0]  len;

    // Dual-destination opcodes reuse [5:1] as a register field, so their
    // bits 5 and 4 must not be read as immediate flags.
    function automatic logic is_dual(input logic [31:0] w);
        return (w[31:25] == DUAL_DST_OP0) || (w[31:25] == DUAL_DST_OP1);
    endfunction

    function automatic logic needs_imm1(input logic [31:0] w);
        return !is_dual(w) && w[5];
    endfunction

    function automatic logic needs_imm2(input logic [31:0] w);
        return !is_dual(w) && w[4];
    endfunction

    logic new_imm1;
    logic new_imm2;

    always_comb begin
        new_imm1 = needs_imm1(mem_word);
        new_imm2 = needs_imm2(mem_word);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            insn  <= '0;
            imm1  <= '0;
            imm2  <= '0;
            bpc   <= RESET_PC;
            len   <= 2'd1;
        end else if (redirect) begin
            // A coincident handshake still completes; no new opcode is captured.
            pc    <= redirect_pc;
            state <= FETCH;
        end else begin
            case (state)
                FETCH, VALID: begin
                    if (state == FETCH || out_ready) begin
                        insn  <= mem_word;
                        bpc   <= pc;
                        pc    <= pc + 32'd1;
                        imm1  <= '0;
                        imm2  <= '0;
                        len   <= 2'd1 + 2'(new_imm1) + 2'(new_imm2);
                        if (new_imm1)
                            state <= IMM1;
                        else if (new_imm2)
                            state <= IMM2;
                        else
                            state <= VALID;
                    end
                end
                IMM1: begin
                    imm1  <= mem_word;
                    pc    <= pc + 32'd1;
                    state <= needs_imm2(insn) ? IMM2 : VALID;
                end
                IMM2: begin
                    imm2  <= mem_word;
                    pc    <= pc + 32'd1;
                    state <= VALID;
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign mem_addr  = pc;
    assign out_valid = (state == VALID);
    assign out_insn  = insn;
    assign out_imm1  = imm1;
    assign out_imm2  = imm2;
    assign out_pc    = bpc;
    assign out_len   = len;

endmodule
